// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle datapath.
// Receives a big-endian byte stream (2-byte length header followed by
// 16-bit words, high byte first) over a valid/ready handshake. It writes
// each assembled word into instruction memory, starting at address 0.
// The datapath is held in reset (cpu_run_o = 0) until a load finishes
// cleanly.
//
// Handshake: a byte moves on a rising clk edge when byte_valid_i and
// byte_ready_o are both high. byte_ready_o is a registered (Moore) output.
// It is high only while the loader is waiting for a header or data byte.
// The producer may hold byte_valid_i low for any number of cycles. The
// loader never times out a stalled producer.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [15:0]       imem_wdata_o,
    output logic              cpu_run_o,
    output logic              done_o,
    output logic              error_o,
    output logic [2:0]        state_o,
    output logic [10:0]       word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_e;

    // The length field is 11 bits wide. Widening it by one bit lets a
    // header of 2047 compare correctly against DEPTH.
    localparam logic [11:0] DEPTH_W = 12'(DEPTH);

    state_e              state_q, state_d;
    logic [10:0]         len_q, len_d;
    logic [10:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                ready_q, we_q, run_q, done_q, err_q;

    logic                xfer;
    logic [10:0]         hdr_len;
    logic [10:0]         cnt_inc;

    assign xfer    = byte_valid_i && ready_q;
    assign hdr_len = {len_q[10:8], byte_in_i};
    assign cnt_inc = cnt_q + 11'd1;

    // Next-state and datapath update rules for the load sequence.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Every load starts again at address 0 with a fresh count.
                if (start_i) begin
                    state_d = S_LEN_HI;
                    len_d   = 11'd0;
                    cnt_d   = 11'd0;
                    addr_d  = '0;
                end
            end
            S_LEN_HI: begin
                // Only the low 3 bits of the high length byte are used.
                if (xfer) begin
                    len_d[10:8] = byte_in_i[2:0];
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = hdr_len;
                    if (hdr_len == 11'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, hdr_len} > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    wdata_d[15:8] = byte_in_i;
                    state_d       = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    wdata_d[7:0] = byte_in_i;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                // The address moves on only when another word follows, so
                // after the last word it still points at the last write.
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_DATA_HI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Outputs are decoded from the next
    // state, so each one is a clean registered level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            len_q   <= 11'd0;
            cnt_q   <= 11'd0;
            addr_q  <= '0;
            wdata_q <= 16'd0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= (state_d == S_LEN_HI)  || (state_d == S_LEN_LO) ||
                       (state_d == S_DATA_HI) || (state_d == S_DATA_LO);
            we_q    <= (state_d == S_WRITE);
            run_q   <= (state_d == S_DONE);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_run_o    = run_q;
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign state_o      = state_q;
    assign word_cnt_o   = cnt_q;

endmodule
